// File: rtl/cic_channel_sched_pkg.sv
// Shared definitions for the CIC channel scheduler: data/config widths, the
// scheduler state encoding and the comb-index clamp.
package cic_channel_sched_pkg;

  localparam int CIC_DW     = 32;
  localparam int CIC_DEC_W  = 16;
  localparam int CIC_COMB_W = 8;
  localparam logic [CIC_COMB_W-1:0] CIC_COMB_MAX = 8'd7;

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } sched_state_e;

  // The CIC comb delay line only has eight taps, so larger indices saturate.
  function automatic logic [CIC_COMB_W-1:0] clamp_comb(input logic [CIC_COMB_W-1:0] comb);
    logic [CIC_COMB_W-1:0] res;
    if (comb > CIC_COMB_MAX) begin
      res = CIC_COMB_MAX;
    end else begin
      res = comb;
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_channel_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above ptr_i, wrapping
// modulo N, as a one-hot vector plus its index.
module cic_channel_sched_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  int sel_s;

  // Scan from the farthest slot back to ptr_i so the nearest request wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    sel_s     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      sel_s = int'(ptr_i) + k;
      if (sel_s >= N) begin
        sel_s = sel_s - N;
      end else begin
        sel_s = sel_s + 0;
      end
      if (req_i[sel_s]) begin
        gnt_idx_o = IW'(sel_s);
        gnt_vld_o = 1'b1;
      end else begin
        gnt_vld_o = gnt_vld_o;
      end
    end
    gnt_o[gnt_idx_o] = gnt_vld_o;
  end

endmodule

// File: rtl/cic_channel_sched.sv
// Controller for the CIC decimator bank: rate configuration, synchronous restart
// with transient blanking, and round-robin serialisation of channel results.
module cic_channel_sched
  import cic_channel_sched_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int DW       = CIC_DW,
  parameter int CW       = 3,
  parameter int DEF_DEC  = 63,
  parameter int DEF_COMB = 1,
  parameter int RST_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [CIC_DEC_W-1:0]  cfg_dec_num,
  input  logic [CIC_COMB_W-1:0] cfg_comb_num,
  output logic [CIC_DEC_W-1:0]  cic_dec_num,
  output logic [CIC_COMB_W-1:0] cic_comb_num,
  output logic                  cic_rst,
  input  logic [NCH*DW-1:0]     ch_data,
  input  logic [NCH-1:0]        ch_rdy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic [CW-1:0]         m_ch,
  output logic [NCH-1:0]        ovf,
  input  logic                  ovf_clr,
  output logic                  busy
);

  localparam int RCW = $clog2(RST_CYC + 1);

  sched_state_e          state_q, state_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [3:0]            warm_cnt_q, warm_cnt_d;
  logic                  cic_rst_q, cic_rst_d, busy_q, busy_d;
  logic [CIC_DEC_W-1:0]  dec_q, dec_d, sh_dec_q, sh_dec_d;
  logic [CIC_COMB_W-1:0] comb_q, comb_d, sh_comb_q, sh_comb_d;
  logic                  pend_q, pend_d;
  logic [NCH*DW-1:0]     hold_data_q, hold_data_d;
  logic [NCH-1:0]        hold_vld_q, hold_vld_d, ovf_q, ovf_d;
  logic [CW-1:0]         rr_ptr_q, rr_ptr_d, m_ch_q, m_ch_d;
  logic                  m_valid_q, m_valid_d;
  logic [DW-1:0]         m_data_q, m_data_d, sel_data_s;
  logic [NCH-1:0]        gnt_s, grant_s, capture_s;
  logic [CW-1:0]         gnt_idx_s;
  logic                  gnt_vld_s, slot_free_s, apply_s;

  cic_channel_sched_rr_arbiter #(.N(NCH), .IW(CW)) u_rr_arbiter (
    .req_i     (hold_vld_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // Sequencing of restart, warm-up and drain, plus the shadow configuration.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = '0;
    warm_cnt_d = warm_cnt_q;
    apply_s    = (state_q == ST_DRAIN) && (hold_vld_q == '0) && !m_valid_q;
    case (state_q)
      ST_RESTART: begin
        warm_cnt_d = 4'd0;
        if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
          state_d = ST_WARMUP;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      ST_WARMUP: begin
        if (ch_rdy[0]) begin
          warm_cnt_d = warm_cnt_q + 4'd1;
          state_d    = (warm_cnt_q == {1'b0, comb_q[2:0]}) ? ST_RUN : ST_WARMUP;
        end else begin
          warm_cnt_d = warm_cnt_q;
        end
      end
      ST_RUN:   state_d = pend_q ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = apply_s ? ST_RESTART : ST_DRAIN;
      default:  state_d = ST_RESTART;
    endcase
    // A write in the same cycle as the apply stays pending for the next restart.
    pend_d    = cfg_wr | (pend_q & ~apply_s);
    sh_dec_d  = cfg_wr ? cfg_dec_num : sh_dec_q;
    sh_comb_d = cfg_wr ? clamp_comb(cfg_comb_num) : sh_comb_q;
    dec_d     = apply_s ? sh_dec_q : dec_q;
    comb_d    = apply_s ? sh_comb_q : comb_q;
    cic_rst_d = (state_d == ST_RESTART);
    busy_d    = (state_d != ST_RUN);
  end

  // Per-channel capture with overrun detection and the output slot.
  always_comb begin
    slot_free_s = !m_valid_q || m_ready;
    grant_s     = slot_free_s ? gnt_s : '0;
    capture_s   = (state_q == ST_RUN) ? ch_rdy : '0;
    sel_data_s  = '0;
    hold_data_d = hold_data_q;
    for (int i = 0; i < NCH; i++) begin
      sel_data_s = sel_data_s | (hold_data_q[i*DW +: DW] & {DW{gnt_s[i]}});
      hold_data_d[i*DW +: DW] = capture_s[i] ? ch_data[i*DW +: DW] : hold_data_q[i*DW +: DW];
    end
    hold_vld_d = (state_q == ST_RESTART) ? '0 : ((hold_vld_q & ~grant_s) | capture_s);
    hold_data_d = (state_q == ST_RESTART) ? '0 : hold_data_d;
    ovf_d      = (ovf_q & ~{NCH{ovf_clr}}) | (capture_s & hold_vld_q & ~grant_s);
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_ch_d     = m_ch_q;
    rr_ptr_d   = rr_ptr_q;
    if (slot_free_s) begin
      m_valid_d = gnt_vld_s;
      if (gnt_vld_s) begin
        m_data_d = sel_data_s;
        m_ch_d   = gnt_idx_s;
        rr_ptr_d = (gnt_idx_s == CW'(NCH - 1)) ? '0 : gnt_idx_s + CW'(1);
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State and output registers; reset restarts the bank with default rates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESTART;
      rst_cnt_q   <= '0;
      warm_cnt_q  <= 4'd0;
      cic_rst_q   <= 1'b1;
      busy_q      <= 1'b1;
      dec_q       <= CIC_DEC_W'(DEF_DEC);
      comb_q      <= CIC_COMB_W'(DEF_COMB);
      sh_dec_q    <= CIC_DEC_W'(DEF_DEC);
      sh_comb_q   <= CIC_COMB_W'(DEF_COMB);
      pend_q      <= 1'b0;
      hold_data_q <= '0;
      hold_vld_q  <= '0;
      ovf_q       <= '0;
      rr_ptr_q    <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ch_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      cic_rst_q   <= cic_rst_d;
      busy_q      <= busy_d;
      dec_q       <= dec_d;
      comb_q      <= comb_d;
      sh_dec_q    <= sh_dec_d;
      sh_comb_q   <= sh_comb_d;
      pend_q      <= pend_d;
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ch_q      <= m_ch_d;
    end
  end

  assign cic_dec_num  = dec_q;
  assign cic_comb_num = comb_q;
  assign cic_rst      = cic_rst_q;
  assign busy         = busy_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_ch         = m_ch_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_cic_channel_sched.sv
// Directed bench for cic_channel_sched: restart/blanking, serialisation,
// back-pressure overrun, reconfiguration and asynchronous reset.
module tb_cic_channel_sched;

  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst, cfg_wr, m_ready, ovf_clr;
  logic [15:0]       cfg_dec_num, cic_dec_num;
  logic [7:0]        cfg_comb_num, cic_comb_num;
  logic              cic_rst, m_valid, busy;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_rdy, ovf;
  logic [DW-1:0]     m_data;
  logic [CW-1:0]     m_ch;
  int                errors = 0;
  int                checks = 0;

  always #5 clk = ~clk;

  cic_channel_sched dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_dec_num(cfg_dec_num),
    .cfg_comb_num(cfg_comb_num), .cic_dec_num(cic_dec_num), .cic_comb_num(cic_comb_num),
    .cic_rst(cic_rst), .ch_data(ch_data), .ch_rdy(ch_rdy), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .ovf(ovf), .ovf_clr(ovf_clr),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [NCH-1:0] mask, input logic [DW-1:0] base);
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = base + DW'(i);
    ch_rdy = mask;
    tick();
    ch_rdy = '0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; cfg_wr = 1'b0; cfg_dec_num = 16'd0; cfg_comb_num = 8'd0;
    ch_data = '0; ch_rdy = '0; m_ready = 1'b1; ovf_clr = 1'b0;
    idle(3);
    checks++; if (cic_rst !== 1'b1) begin errors++; $display("FAIL reset_cic_rst: got %0b want 1", cic_rst); end
    checks++; if (cic_dec_num !== 16'd63) begin errors++; $display("FAIL reset_dec: got %0d want 63", cic_dec_num); end
    checks++; if (cic_comb_num !== 8'd1) begin errors++; $display("FAIL reset_comb: got %0d want 1", cic_comb_num); end
    checks++; if ({m_valid, m_data, m_ch} !== 36'd0) begin errors++; $display("FAIL reset_out: got v=%0b d=%h ch=%0d want 0", m_valid, m_data, m_ch); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h want 00", ovf); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b want 1", busy); end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (cic_rst === 1'b1) n++;
      tick();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL restart_len: got %0d want 2", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL warmup_busy: got %0b want 1", busy); end
  endtask

  task automatic test_warmup();
    pulse(8'hFF, 32'h100);
    idle(3);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL warm_p1: got m_valid=%0b want 0", m_valid); end
    pulse(8'hFF, 32'h200);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL warm_run: got busy=%0b want 0", busy); end
    idle(3);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL warm_p2: got m_valid=%0b want 0", m_valid); end
    pulse(8'hFF, 32'h300);
    tick();
    checks++; if ({m_valid, m_ch, m_data} !== {1'b1, 3'd0, 32'h300}) begin errors++; $display("FAIL warm_p3: got v=%0b ch=%0d d=%h want 1/0/300", m_valid, m_ch, m_data); end
    idle(10);
  endtask

  task automatic test_all_channels();
    pulse(8'hFF, 32'h1000);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL all_latency: got m_valid=%0b want 0", m_valid); end
    for (int k = 0; k < NCH; k++) begin
      tick();
      checks++;
      if ({m_valid, m_ch, m_data} !== {1'b1, CW'(k), 32'h1000 + DW'(k)}) begin
        errors++; $display("FAIL all_seq%0d: got v=%0b ch=%0d d=%h want ch=%0d", k, m_valid, m_ch, m_data, k);
      end
    end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL all_end: got m_valid=%0b want 0", m_valid); end
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL all_ovf: got %h want 00", ovf); end
  endtask

  task automatic test_backpressure();
    int ech;
    m_ready = 1'b0;
    pulse(8'hFF, 32'h2000);
    tick();
    idle(2);
    pulse(8'hFF, 32'h3000);
    idle(2);
    pulse(8'hFF, 32'h4000);
    idle(1);
    checks++; if (ovf !== 8'hFF) begin errors++; $display("FAIL bp_ovf: got %h want FF", ovf); end
    checks++; if ({m_valid, m_ch, m_data} !== {1'b1, 3'd0, 32'h2000}) begin errors++; $display("FAIL bp_frozen: got v=%0b ch=%0d d=%h want 1/0/2000", m_valid, m_ch, m_data); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 8'h00) begin errors++; $display("FAIL bp_clr: got %h want 00", ovf); end
    m_ready = 1'b1;
    for (int k = 1; k <= NCH; k++) begin
      tick();
      ech = k % NCH;
      checks++;
      if ({m_valid, m_ch, m_data} !== {1'b1, CW'(ech), 32'h4000 + DW'(ech)}) begin
        errors++; $display("FAIL bp_seq%0d: got v=%0b ch=%0d d=%h want ch=%0d d=%h", k, m_valid, m_ch, m_data, ech, 32'h4000 + ech);
      end
    end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got m_valid=%0b want 0", m_valid); end
  endtask

  task automatic test_cfg_drain();
    int  n;
    int  blank;
    bit  found;
    m_ready = 1'b0;
    pulse(8'h1C, 32'h5000);
    tick();
    checks++; if ({m_valid, m_ch, m_data} !== {1'b1, 3'd2, 32'h5002}) begin errors++; $display("FAIL cfg_q0: got v=%0b ch=%0d d=%h want 1/2/5002", m_valid, m_ch, m_data); end
    cfg_wr = 1'b1; cfg_dec_num = 16'd15; cfg_comb_num = 8'd9;
    tick();
    cfg_wr = 1'b0;
    checks++; if (cic_dec_num !== 16'd63) begin errors++; $display("FAIL cfg_early: got dec=%0d want 63", cic_dec_num); end
    m_ready = 1'b1;
    tick();
    checks++; if ({m_valid, m_ch, m_data} !== {1'b1, 3'd3, 32'h5003}) begin errors++; $display("FAIL cfg_q1: got v=%0b ch=%0d d=%h want 1/3/5003", m_valid, m_ch, m_data); end
    tick();
    checks++; if ({m_valid, m_ch, m_data} !== {1'b1, 3'd4, 32'h5004}) begin errors++; $display("FAIL cfg_q2: got v=%0b ch=%0d d=%h want 1/4/5004", m_valid, m_ch, m_data); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL cfg_drained: got m_valid=%0b want 0", m_valid); end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (cic_rst === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL cfg_restart: got no cic_rst within 10 cycles want pulse"); end
    checks++; if ({cic_dec_num, cic_comb_num} !== {16'd15, 8'd7}) begin errors++; $display("FAIL cfg_apply: got dec=%0d comb=%0d want 15/7", cic_dec_num, cic_comb_num); end
    n = 0;
    while (cic_rst === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL cfg_rst_len: got %0d want 2", n); end
    blank = 0;
    for (int p = 0; p < 8; p++) begin
      pulse(8'h01, 32'h6000 + DW'(p));
      idle(3);
      if (m_valid !== 1'b0) blank++;
    end
    checks++; if (blank !== 0) begin errors++; $display("FAIL cfg_blank: got %0d emitted periods want 0", blank); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_run: got busy=%0b want 0", busy); end
    pulse(8'h01, 32'h6100);
    tick();
    checks++; if ({m_valid, m_ch, m_data} !== {1'b1, 3'd0, 32'h6100}) begin errors++; $display("FAIL cfg_first: got v=%0b ch=%0d d=%h want 1/0/6100", m_valid, m_ch, m_data); end
    idle(2);
  endtask

  task automatic test_reset_mid_burst();
    int stale;
    m_ready = 1'b0;
    pulse(8'hFF, 32'h7000);
    tick();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got m_valid=%0b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_async: got m_valid=%0b want 0", m_valid); end
    checks++; if ({cic_dec_num, cic_comb_num, cic_rst, busy} !== {16'd63, 8'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL mid_defaults: got dec=%0d comb=%0d rst=%0b busy=%0b want 63/1/1/1", cic_dec_num, cic_comb_num, cic_rst, busy); end
    m_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    checks++; if ({cic_rst, busy} !== 2'b01) begin errors++; $display("FAIL mid_warmup: got rst=%0b busy=%0b want 0/1", cic_rst, busy); end
  endtask

  task automatic test_double_cfg();
    int   rises;
    logic prev;
    cfg_wr = 1'b1; cfg_dec_num = 16'd31; cfg_comb_num = 8'd1;
    tick();
    cfg_wr = 1'b0;
    idle(2);
    cfg_wr = 1'b1; cfg_dec_num = 16'd127; cfg_comb_num = 8'd1;
    tick();
    cfg_wr = 1'b0;
    checks++; if (cic_dec_num !== 16'd63) begin errors++; $display("FAIL dbl_early: got dec=%0d want 63", cic_dec_num); end
    rises = 0;
    prev  = cic_rst;
    for (int c = 0; c < 60; c++) begin
      ch_rdy = (c % 4 == 0) ? 8'h01 : 8'h00;
      tick();
      if (cic_rst === 1'b1 && prev === 1'b0) rises++;
      prev = cic_rst;
    end
    ch_rdy = '0;
    checks++; if (rises !== 1) begin errors++; $display("FAIL dbl_restarts: got %0d want 1", rises); end
    checks++; if (cic_dec_num !== 16'd127) begin errors++; $display("FAIL dbl_dec: got %0d want 127", cic_dec_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dbl_run: got busy=%0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_all_channels();
    test_backpressure();
    test_cfg_drain();
    test_reset_mid_burst();
    test_double_cfg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
